// File: rtl/glyph_pkg.sv
// glyph_pkg: shared definitions for the glyph stroke drawer.
//   - stroke word layout (STROKE_W bits: valid, dir, x0, y0, len)
//   - letter codes for the glyphs held in glyph_rom
//   - drawer FSM state encoding
//   - helpers to build stroke words and convert half-unit offsets to pixels
package glyph_pkg;

    localparam int STROKE_W = 8;

    // Stroke word field positions (2-bit fields are addressed with +: 2)
    localparam int S_VALID = 7;
    localparam int S_DIR   = 6;
    localparam int S_X0    = 4;
    localparam int S_Y0    = 2;
    localparam int S_LEN   = 0;

    localparam logic DIR_H = 1'b0;
    localparam logic DIR_V = 1'b1;

    // Letter codes: 0..25 = A..Z, 26 = blank, 27..31 unused
    localparam logic [4:0] L_C     = 5'd2;
    localparam logic [4:0] L_E     = 5'd4;
    localparam logic [4:0] L_F     = 5'd5;
    localparam logic [4:0] L_H     = 5'd7;
    localparam logic [4:0] L_I     = 5'd8;
    localparam logic [4:0] L_L     = 5'd11;
    localparam logic [4:0] L_O     = 5'd14;
    localparam logic [4:0] L_T     = 5'd19;
    localparam logic [4:0] L_U     = 5'd20;
    localparam logic [4:0] L_BLANK = 5'd26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Build a valid stroke word
    function automatic logic [STROKE_W-1:0] mk_stroke(input logic dir, input logic [1:0] x0,
                                                      input logic [1:0] y0, input logic [1:0] len);
        return {1'b1, dir, x0, y0, len};
    endfunction

    // Half-unit offset -> pixels, clamped so unit 2 lands on the last pixel of the box
    function automatic int unit_off(input logic [1:0] u, input int half, input int seg_len);
        int v;
        v = int'(u) * half;
        return (v > seg_len - 1) ? seg_len - 1 : v;
    endfunction

endpackage

// File: rtl/glyph_rom.sv
// glyph_rom: combinational stroke table, (letter, stroke index) -> stroke word.
// Ports:
//   letter_i  glyph code (0..25 A..Z, 26 blank, 27..31 unused)
//   idx_i     stroke slot 0..MAX_STROKES-1
//   stroke_o  stroke word; all zero (invalid) for empty slots, blank and unlisted codes
module glyph_rom
    import glyph_pkg::*;
#(
    parameter int MAX_STROKES = 8,
    parameter int IDX_W       = (MAX_STROKES > 1) ? $clog2(MAX_STROKES) : 1
) (
    input  logic [4:0]          letter_i,
    input  logic [IDX_W-1:0]    idx_i,
    output logic [STROKE_W-1:0] stroke_o
);

    always_comb begin
        stroke_o = '0;
        case (letter_i)
            L_C: case (int'(idx_i))
                0: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd0, 2'd2);
                1: stroke_o = mk_stroke(DIR_V, 2'd0, 2'd0, 2'd2);
                2: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd2, 2'd2);
                default: ;
            endcase
            L_E: case (int'(idx_i))
                0: stroke_o = mk_stroke(DIR_V, 2'd0, 2'd0, 2'd2);
                1: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd0, 2'd2);
                2: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd1, 2'd2);
                3: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd2, 2'd2);
                default: ;
            endcase
            L_F: case (int'(idx_i))
                0: stroke_o = mk_stroke(DIR_V, 2'd0, 2'd0, 2'd2);
                1: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd0, 2'd2);
                2: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd1, 2'd2);
                default: ;
            endcase
            L_H: case (int'(idx_i))
                0: stroke_o = mk_stroke(DIR_V, 2'd0, 2'd0, 2'd2);
                1: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd1, 2'd2);
                2: stroke_o = mk_stroke(DIR_V, 2'd2, 2'd0, 2'd2);
                default: ;
            endcase
            L_I: case (int'(idx_i))
                0: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd0, 2'd2);
                1: stroke_o = mk_stroke(DIR_V, 2'd1, 2'd0, 2'd2);
                2: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd2, 2'd2);
                default: ;
            endcase
            L_L: case (int'(idx_i))
                0: stroke_o = mk_stroke(DIR_V, 2'd0, 2'd0, 2'd2);
                1: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd2, 2'd2);
                default: ;
            endcase
            L_O: case (int'(idx_i))
                0: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd0, 2'd2);
                1: stroke_o = mk_stroke(DIR_V, 2'd0, 2'd0, 2'd2);
                2: stroke_o = mk_stroke(DIR_V, 2'd2, 2'd0, 2'd2);
                3: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd2, 2'd2);
                default: ;
            endcase
            L_T: case (int'(idx_i))
                0: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd0, 2'd2);
                1: stroke_o = mk_stroke(DIR_V, 2'd1, 2'd0, 2'd2);
                default: ;
            endcase
            L_U: case (int'(idx_i))
                0: stroke_o = mk_stroke(DIR_V, 2'd0, 2'd0, 2'd2);
                1: stroke_o = mk_stroke(DIR_H, 2'd0, 2'd2, 2'd2);
                2: stroke_o = mk_stroke(DIR_V, 2'd2, 2'd0, 2'd2);
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

// File: rtl/glyph_stroke_drawer.sv
// glyph_stroke_drawer: draws one glyph as a sequence of horizontal/vertical strokes,
// one pixel per cycle, for the VGA adapter.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   start                 1-cycle draw request, accepted only in IDLE with hold low
//   hold                  stall; freezes FSM/counters, forces plot low
//   letter                glyph code, latched on accepted start
//   origin_x/origin_y     top-left of glyph box, latched on accepted start
//   colour_in, erase      pixel colour and erase flag, latched on accepted start
//   out_x/out_y           current pixel (wraps modulo coordinate width)
//   colour_out            pixel colour (0 when erasing)
//   plot                  write strobe, one per pixel
//   busy                  high from FETCH through DONE
//   done                  1-cycle pulse at end of glyph
module glyph_stroke_drawer
    import glyph_pkg::*;
#(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int SEG_LEN     = 32,
    parameter int MAX_STROKES = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           hold,
    input  logic [4:0]     letter,
    input  logic [X_W-1:0] origin_x,
    input  logic [Y_W-1:0] origin_y,
    input  logic [2:0]     colour_in,
    input  logic           erase,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic [2:0]     colour_out,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    localparam int HALF  = SEG_LEN / 2;
    localparam int PIX_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
    localparam int IDX_W = (MAX_STROKES > 1) ? $clog2(MAX_STROKES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_STROKES - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PIX_W-1:0]     pix_q, pix_d;
    // valid bit is not kept: a stroke only reaches DRAW if it was valid
    logic [S_DIR:0]       stroke_q, stroke_d;
    logic [4:0]           letter_q, letter_d;
    logic [X_W-1:0]       org_x_q, org_x_d;
    logic [Y_W-1:0]       org_y_q, org_y_d;
    logic [2:0]           colour_q, colour_d;
    logic                 erase_q, erase_d;

    logic [STROKE_W-1:0]  rom_word;
    int                   fixed_off, along_off, x_off, y_off;
    logic                 last_pix;

    glyph_rom #(
        .MAX_STROKES (MAX_STROKES),
        .IDX_W       (IDX_W)
    ) u_rom (
        .letter_i (letter_q),
        .idx_i    (idx_q),
        .stroke_o (rom_word)
    );

    // Pixel offsets inside the glyph box for the current stroke/pixel
    always_comb begin
        fixed_off = 0;
        along_off = 0;
        x_off     = 0;
        y_off     = 0;
        if (stroke_q[S_DIR] == DIR_V) begin
            fixed_off = unit_off(stroke_q[S_X0 +: 2], HALF, SEG_LEN);
            along_off = unit_off(stroke_q[S_Y0 +: 2], HALF, SEG_LEN) + int'(pix_q);
            x_off     = fixed_off;
            y_off     = along_off;
        end else begin
            fixed_off = unit_off(stroke_q[S_Y0 +: 2], HALF, SEG_LEN);
            along_off = unit_off(stroke_q[S_X0 +: 2], HALF, SEG_LEN) + int'(pix_q);
            x_off     = along_off;
            y_off     = fixed_off;
        end
        // stroke ends at its length or at the box edge, whichever comes first
        last_pix = (int'(pix_q) == int'(stroke_q[S_LEN +: 2]) * HALF - 1) ||
                   (along_off >= SEG_LEN - 1);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pix_d    = pix_q;
        stroke_d = stroke_q;
        letter_d = letter_q;
        org_x_d  = org_x_q;
        org_y_d  = org_y_q;
        colour_d = colour_q;
        erase_d  = erase_q;
        if (!hold) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_FETCH;
                        idx_d    = '0;
                        pix_d    = '0;
                        letter_d = letter;
                        org_x_d  = origin_x;
                        org_y_d  = origin_y;
                        colour_d = colour_in;
                        erase_d  = erase;
                    end
                end
                ST_FETCH: begin
                    stroke_d = rom_word[S_DIR:0];
                    pix_d    = '0;
                    if (!rom_word[S_VALID]) begin
                        state_d = ST_DONE;
                    end else if (rom_word[S_LEN +: 2] == 2'd0) begin
                        // zero-length slot: skip it without drawing
                        if (idx_q == IDX_LAST) state_d = ST_DONE;
                        else                   idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        state_d = ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (last_pix) begin
                        pix_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            pix_q    <= '0;
            stroke_q <= '0;
            letter_q <= '0;
            org_x_q  <= '0;
            org_y_q  <= '0;
            colour_q <= '0;
            erase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pix_q    <= pix_d;
            stroke_q <= stroke_d;
            letter_q <= letter_d;
            org_x_q  <= org_x_d;
            org_y_q  <= org_y_d;
            colour_q <= colour_d;
            erase_q  <= erase_d;
        end
    end

    // Coordinates wrap modulo the port width; no clipping
    assign out_x      = X_W'(int'(org_x_q) + x_off);
    assign out_y      = Y_W'(int'(org_y_q) + y_off);
    assign colour_out = erase_q ? 3'b000 : colour_q;
    assign plot       = (state_q == ST_DRAW) && !hold;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_glyph_stroke_drawer.sv
module tb_glyph_stroke_drawer;

    logic       clk = 1'b0;
    logic       reset, start, hold, erase;
    logic [4:0] letter;
    logic [7:0] origin_x, out_x;
    logic [6:0] origin_y, out_y;
    logic [2:0] colour_in, colour_out;
    logic       plot, busy, done;

    always #10 clk = ~clk;

    glyph_stroke_drawer #(.X_W(8), .Y_W(7), .SEG_LEN(32), .MAX_STROKES(8)) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold), .letter(letter),
        .origin_x(origin_x), .origin_y(origin_y), .colour_in(colour_in), .erase(erase),
        .out_x(out_x), .out_y(out_y), .colour_out(colour_out),
        .plot(plot), .busy(busy), .done(done)
    );

    typedef struct {
        int letter, ox, oy, col, er;
        int n, fx, fy, px, py, lx, ly, dc, ecol;
    } vec_t;

    vec_t tab[8];
    int checks = 0, failures = 0;
    int r_plots, r_fc, r_fx, r_fy, r_px, r_py, r_lx, r_ly;
    int r_done, r_donecnt, r_busy, r_badcol, r_holdbad, r_rstbad;

    task chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Start a draw and watch it cycle by cycle; cycle 1 is the one after the start edge.
    task run(input vec_t v, input int rs_c, input int h_lo, input int h_hi,
             input int hx, input int hy, input int rst_c);
        @(negedge clk);
        letter = 5'(v.letter); origin_x = 8'(v.ox); origin_y = 7'(v.oy);
        colour_in = 3'(v.col); erase = v.er[0]; start = 1'b1; hold = 1'b0;
        r_plots = 0; r_fc = -1; r_fx = -1; r_fy = -1; r_px = -1; r_py = -1; r_lx = -1; r_ly = -1;
        r_done = -1; r_donecnt = 0; r_busy = 0; r_badcol = 0; r_holdbad = 0; r_rstbad = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == rs_c);
            if (cyc == rs_c) begin
                letter = 5'd8; origin_x = 8'd0; origin_y = 7'd0; colour_in = 3'd0;
            end
            hold  = (cyc >= h_lo && cyc <= h_hi);
            reset = (cyc == rst_c);
            @(negedge clk);
            if (plot) begin
                r_plots++;
                if (r_plots == 1) begin r_fc = cyc; r_fx = out_x; r_fy = out_y; end
                if (r_plots == 33) begin r_px = out_x; r_py = out_y; end
                r_lx = out_x; r_ly = out_y;
                if (colour_out != 3'(v.ecol)) r_badcol++;
            end
            if (busy) r_busy++;
            if (done) begin r_donecnt++; r_done = cyc; end
            if (hold && (plot || int'(out_x) != hx || int'(out_y) != hy)) r_holdbad++;
            if (rst_c > 0 && cyc >= rst_c && cyc <= rst_c + 1 && (plot || busy || done)) r_rstbad++;
            if (r_done > 0 && cyc > r_done) break;
        end
        start = 1'b0; hold = 1'b0; reset = 1'b0;
    endtask

    task check_vec(input string nm, input vec_t v);
        chk({nm, ".plots"}, r_plots, v.n);
        if (v.n > 0) begin
            chk({nm, ".first_cyc"}, r_fc, 2);
            chk({nm, ".first_x"}, r_fx, v.fx);
            chk({nm, ".first_y"}, r_fy, v.fy);
            chk({nm, ".p33_x"}, r_px, v.px);
            chk({nm, ".p33_y"}, r_py, v.py);
            chk({nm, ".last_x"}, r_lx, v.lx);
            chk({nm, ".last_y"}, r_ly, v.ly);
            chk({nm, ".bad_colour"}, r_badcol, 0);
        end
        chk({nm, ".done_cyc"}, r_done, v.dc);
        chk({nm, ".done_cnt"}, r_donecnt, 1);
        chk({nm, ".busy_cycles"}, r_busy, v.dc);
    endtask

    initial begin
        //         letter ox   oy  col er  n   fx   fy   px   py   lx  ly  dc   ecol
        tab[0] = '{7,     58,  29, 7,  0,  96, 58,  29,  58,  45,  89, 60, 101, 7};  // H
        tab[1] = '{26,    58,  29, 7,  0,  0,  0,   0,   0,   0,   0,  0,  2,   7};  // blank
        tab[2] = '{7,     58,  29, 5,  1,  96, 58,  29,  58,  45,  89, 60, 101, 0};  // H erase
        tab[3] = '{11,    10,  20, 3,  0,  64, 10,  20,  10,  51,  41, 51, 68,  3};  // L
        tab[4] = '{19,    100, 0,  2,  0,  64, 100, 0,   116, 0,  116, 31, 68,  2};  // T
        tab[5] = '{29,    1,   1,  1,  0,  0,  0,   0,   0,   0,   0,  0,  2,   1};  // unused code
        tab[6] = '{8,     5,   5,  6,  0,  96, 5,   5,   21,  5,   36, 36, 101, 6};  // I
        tab[7] = '{7,     250, 100, 1, 0,  96, 250, 100, 250, 116, 25, 3,  101, 1};  // H wrap

        reset = 1'b1; start = 1'b0; hold = 1'b0; erase = 1'b0;
        letter = '0; origin_x = '0; origin_y = '0; colour_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.plot", int'(plot), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.out_x", int'(out_x), 0);
        chk("rst.out_y", int'(out_y), 0);
        chk("rst.colour", int'(colour_out), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run(tab[i], 0, 0, -1, 0, 0, 0);
            check_vec($sformatf("vec%0d", i), tab[i]);
        end

        // start re-pulsed mid-draw with different inputs: must be ignored
        run(tab[0], 40, 0, -1, 0, 0, 0);
        check_vec("restart", tab[0]);

        // hold cycles 20..24: frozen on pixel 18 (58,47), done slips by 5
        run(tab[0], 0, 20, 24, 58, 47, 0);
        chk("hold.plots", r_plots, 96);
        chk("hold.frozen", r_holdbad, 0);
        chk("hold.last_x", r_lx, 89);
        chk("hold.last_y", r_ly, 60);
        chk("hold.done_cyc", r_done, 106);
        chk("hold.busy_cycles", r_busy, 106);

        // reset at cycle 50 aborts: 47 pixels drawn, no done
        run(tab[7], 0, 0, -1, 0, 0, 50);
        chk("abort.outputs_low", r_rstbad, 0);
        chk("abort.done_cnt", r_donecnt, 0);
        chk("abort.plots", r_plots, 47);
        chk("abort.busy_cycles", r_busy, 49);

        // new start accepted after the abort
        run(tab[4], 0, 0, -1, 0, 0, 0);
        check_vec("post_abort", tab[4]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
